fp_exp_arbiter: RTL

Shares one pipelined single-precision `fpExp` core between `NUM_REQ` effect-chain clients. Each client can have one exponentiation in flight at a time. Accepts at most one operand per cycle from the requesters, using round-robin priority. Carries a requester tag alongside the core's fixed latency and routes each result back as a one-cycle pulse to its owner. Sits between the effect datapaths (e.g. compressor/envelope gain stages) and the floating-point arithmetic library.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_exp_core.sv | 37 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fp_exp_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point library constants, plus the marker transform applied by
// the behavioural fpExp stand-in so results can be traced back to operands.
package fp_pkg;

  localparam int FP_W           = 32;
  localparam int FP_EXP_LATENCY = 17;

  // Offset chosen so that the stand-in maps 1.0 (0x3F800000) onto e (0x402DF854).
  localparam logic [FP_W-1:0] FP_EXP_MARK = 32'h00AD_F854;

  function automatic logic [FP_W-1:0] fp_exp_marker(input logic [FP_W-1:0] x);
    return x + FP_EXP_MARK;
  endfunction

endpackage

// File: rtl/fp_exp_core.sv
// Behavioural stand-in for the library fpExp core: a clock-enabled delay line of
// LATENCY stages that applies the package marker transform on entry.
module fpExp
  import fp_pkg::*;
#(
  parameter int LATENCY = FP_EXP_LATENCY,
  parameter int DATA_W  = FP_W
) (
  input  logic              clk,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] stage_q [LATENCY];
  logic [DATA_W-1:0] stage_d [LATENCY];

  always_comb begin
    stage_d = stage_q;
    if (clk_en) begin
      stage_d[0] = fp_exp_marker(data);
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // NOTE: datapath storage carries no reset; its contents only matter when a
  // matching valid tag travels alongside, so clearing it would just cost area.
  // NOTE: non-blocking assignments keep every stage sampling the pre-edge value.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign result = stage_q[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester after the last
// granted one; the pointer moves only when the grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         elig,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] last_q, last_d;

  // Scan farthest-first so the nearest eligible requester after last_q wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(last_q) + off) % N;
      if (elig[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant_idx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= IDX_W'(N - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/fp_exp_arbiter.sv
// Shares one pipelined fpExp core among NUM_REQ clients: round-robin issue, a
// tag pipe in lockstep with the core, and one-cycle result strobes to owners.
module fp_exp_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = FP_EXP_LATENCY,
  parameter int DATA_W  = FP_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          busy,
  output logic [$clog2(LATENCY+1)-1:0]  in_flight
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] elig, grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept, core_en, resp_fire;
  logic [DATA_W-1:0]  core_data, core_result;

  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [IDX_W-1:0]   tag_idx_q [LATENCY];
  logic [IDX_W-1:0]   tag_idx_d [LATENCY];

  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic               busy_q, busy_d;

  // Reset also masks eligibility so req_ready is low while reset_n is held.
  assign elig = req_valid & ~pending_q & {NUM_REQ{reset_n}};

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .elig      (elig),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign core_en   = accept | (|tag_valid_q);

  always_comb begin
    core_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) core_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  fpExp #(.LATENCY(LATENCY), .DATA_W(DATA_W)) u_core (
    .clk    (clock),
    .clk_en (core_en),
    .data   (core_data),
    .result (core_result)
  );

  // Tag pipe advances only with the core enable so tags stay aligned with data.
  always_comb begin
    tag_valid_d = tag_valid_q;
    tag_idx_d   = tag_idx_q;
    if (core_en) begin
      tag_valid_d  = {tag_valid_q[LATENCY-2:0], accept};
      tag_idx_d[0] = grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        tag_idx_d[s] = tag_idx_q[s-1];
      end
    end
  end

  assign resp_fire  = tag_valid_q[LATENCY-1] & core_en;
  assign resp_valid = resp_fire ? (NUM_REQ'(1) << tag_idx_q[LATENCY-1]) : '0;
  assign resp_data  = resp_fire ? core_result : '0;

  always_comb begin
    pending_d   = (pending_q | grant) & ~resp_valid;
    in_flight_d = in_flight_q;
    if (accept && !resp_fire)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!accept && resp_fire) in_flight_d = in_flight_q - CNT_W'(1);
    busy_d = (in_flight_d != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      tag_valid_q <= '0;
      in_flight_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      tag_valid_q <= tag_valid_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    tag_idx_q <= tag_idx_d;
  end

  assign busy      = busy_q;
  assign in_flight = in_flight_q;

endmodule
